// File: rtl/oam_dma_controller.sv
// 2A03 sprite DMA: a CPU write to the trigger address stalls the core and copies
// one 256-byte page to the PPU OAM data port, one get/put byte pair at a time.
`timescale 1ns/1ps
module oam_dma_controller #(
    parameter logic [15:0] DMA_TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR    = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic [15:0] i_cpu_address,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_cpu_data,
    input  logic [7:0]  i_bus_data,
    output logic        o_rdy,
    output logic        o_dma_active,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } state_e;

    state_e      r_state;
    logic        r_parity;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic [7:0]  r_latch;

    state_e      w_state_next;
    logic [7:0]  w_page_next;
    logic [7:0]  w_index_next;
    logic [7:0]  w_latch_next;
    logic        w_trigger;

    assign w_trigger = !i_cpu_rw && (i_cpu_address == DMA_TRIGGER_ADDR);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_parity <= 1'b0;
            r_page   <= 8'h00;
            r_index  <= 8'h00;
            r_latch  <= 8'h00;
        end else if (i_clk_en) begin
            r_state  <= w_state_next;
            r_parity <= ~r_parity;
            r_page   <= w_page_next;
            r_index  <= w_index_next;
            r_latch  <= w_latch_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_page_next  = r_page;
        w_index_next = r_index;
        w_latch_next = r_latch;
        case (r_state)
            StIdle: begin
                if (w_trigger) begin
                    w_page_next  = i_cpu_data;
                    w_index_next = 8'h00;
                    w_state_next = StHalt;
                end
            end
            // Parity after this edge is ~r_parity; READ must land on a get cycle (0).
            StHalt:  w_state_next = r_parity ? StRead : StAlign;
            StAlign: w_state_next = StRead;
            StRead: begin
                w_latch_next = i_bus_data;
                w_state_next = StWrite;
            end
            StWrite: begin
                if (r_index == 8'hFF) begin
                    w_state_next = StIdle;
                end else begin
                    w_index_next = r_index + 8'h01;
                    w_state_next = StRead;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_rdy        = (r_state == StIdle);
        o_dma_active = 1'b0;
        o_address    = 16'h0000;
        o_rw         = 1'b1;
        o_data       = 8'h00;
        case (r_state)
            StRead: begin
                o_dma_active = 1'b1;
                o_address    = {r_page, r_index};
            end
            StWrite: begin
                o_dma_active = 1'b1;
                o_address    = OAM_DATA_ADDR;
                o_rw         = 1'b0;
                o_data       = r_latch;
            end
            default: ;
        endcase
    end

endmodule
